// File: rtl/q_8_34b_pkg.sv
// Shared types and constants for the q_8_34b ones-counter: controller states,
// default operand width and a popcount reference.
package q_8_34b_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_1    = 2'd1,
    S_2    = 2'd2,
    S_3    = 2'd3
  } state_t;

  function automatic int unsigned popcnt(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/q_8_34b_hold_reg.sv
// One-entry valid/ready holding register; refills in the same cycle it drains.
module q_8_34b_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  // Handshake: a word moves on any edge where valid&ready; a producer holds
  // valid and data steady until that edge, and ready may depend on the sink only.
  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;
  logic         push, pop;

  always_comb begin
    in_ready = !full_q || out_ready;
    push     = in_valid && in_ready;
    pop      = full_q && out_ready;
    full_d   = full_q;
    data_d   = data_q;
    if (push) begin
      full_d = 1'b1;
      data_d = in_data;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = full_q;

endmodule

// File: rtl/q_8_34b_dp.sv
// Ones-counter datapath: operand in-stage, R1/R2/E core driven by the q_8_34b
// controller, and a result out-stage carrying the final count.
module q_8_34b_dp
  import q_8_34b_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              start,
  input  logic              rdy,
  input  logic              load_regs,
  input  logic              incr_r2,
  input  logic              shift,
  output logic              zero,
  output logic              E,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] r1_q, r1_d;
  logic [CNT_W-1:0]  r2_q, r2_d;
  logic              e_q, e_d;
  logic [DATA_W-1:0] op_data;
  logic              in_full;
  logic              out_free;
  logic              done;
  logic [CNT_W-1:0]  r2_inc;

  // The controller pops the in-stage with load_regs.
  q_8_34b_hold_reg #(.W(DATA_W)) u_in_stage (
    .clk       (clk),
    .rst_b     (rst_b),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (op_data),
    .out_valid (in_full),
    .out_ready (load_regs)
  );

  always_comb begin
    r1_d = r1_q;
    r2_d = r2_q;
    e_d  = e_q;
    if (load_regs) begin
      r1_d = op_data;
      r2_d = '1;
      e_d  = 1'b0;
    end else if (incr_r2) begin
      r2_d = r2_inc;
    end else if (shift) begin
      e_d  = r1_q[DATA_W-1];
      r1_d = {r1_q[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r1_q <= '0;
      r2_q <= '0;
      e_q  <= 1'b0;
    end else begin
      r1_q <= r1_d;
      r2_q <= r2_d;
      e_q  <= e_d;
    end
  end

  assign r2_inc = r2_q + CNT_ONE;
  assign zero   = (r1_q == '0);
  assign E      = e_q;
  assign done   = incr_r2 && zero;
  // Starting only with an empty out-stage means a finished count always has a slot.
  assign start  = in_full && rdy && !out_valid;

  // The final increment is still in flight on the done edge, so capture R2+1.
  q_8_34b_hold_reg #(.W(CNT_W)) u_out_stage (
    .clk       (clk),
    .rst_b     (rst_b),
    .in_data   (r2_inc),
    .in_valid  (done),
    .in_ready  (out_free),
    .out_data  (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  a_load_needs_operand: assert property (@(posedge clk) disable iff (!rst_b)
    load_regs |-> in_full);
  a_single_op: assert property (@(posedge clk) disable iff (!rst_b)
    $onehot0({load_regs, incr_r2, shift}));
  a_load_in_idle: assert property (@(posedge clk) disable iff (!rst_b)
    load_regs |-> rdy);
  a_done_slot_free: assert property (@(posedge clk) disable iff (!rst_b)
    done |-> (out_free && !out_valid));

endmodule

// File: tb/tb_q_8_34b_dp.sv
// Bench for q_8_34b_dp: plays the controller and both stream ends, checks every
// result against a popcount model through an expected-result queue.
module tb_q_8_34b_dp;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_b;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              start;
  logic              rdy;
  logic              load_regs;
  logic              incr_r2;
  logic              shift;
  logic              zero;
  logic              e_out;
  logic [CNT_W-1:0]  out_count;
  logic              out_valid;
  logic              out_ready;

  q_8_34b_dp #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .start     (start),
    .rdy       (rdy),
    .load_regs (load_regs),
    .incr_r2   (incr_r2),
    .shift     (shift),
    .zero      (zero),
    .E         (e_out),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [CNT_W-1:0]  exp_q[$];
  logic [DATA_W-1:0] feed_d_q[$];
  logic [CNT_W-1:0]  feed_e_q[$];
  logic [DATA_W-1:0] ld_q[$];

  int          ctrl_st   = 0;
  int          ctrl_nst  = 0;
  bit          hold_offer = 0;
  bit          rst_next  = 0;
  bit          prev_ov   = 0;
  int          cyc       = 0;
  int          load_cyc  = 0;
  int          last_lat  = -1;
  int          ov_rises  = 0;
  logic [DATA_W-1:0] shadow = '0;
  logic        shadow_e  = 1'b0;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [CNT_W-1:0]  c;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [CNT_W-1:0] ref_ones(input logic [DATA_W-1:0] v);
    int unsigned x;
    int unsigned n;
    x = v;
    n = 0;
    while (x != 0) begin
      n = n + (x % 2);
      x = x / 2;
    end
    return CNT_W'(n);
  endfunction

  task automatic push_op(input logic [DATA_W-1:0] d, input logic [CNT_W-1:0] c);
    feed_d_q.push_back(d);
    feed_e_q.push_back(c);
  endtask

  // One clock: controller decision, stream drive, then predicted handshakes.
  task automatic tick(input bit offer, input bit ordy);
    @(negedge clk);
    cyc++;
    rst_b = rst_next;
    if (!rst_b) begin
      ctrl_st  = 0;
      ctrl_nst = 0;
    end else begin
      ctrl_st = ctrl_nst;
    end
    load_regs = 1'b0;
    incr_r2   = 1'b0;
    shift     = 1'b0;
    rdy       = rst_b && (ctrl_st == 0);
    out_ready = ordy;
    if (hold_offer || (offer && feed_d_q.size() > 0)) begin
      in_valid = 1'b1;
      in_data  = feed_d_q[0];
    end else begin
      in_valid = 1'b0;
      in_data  = DATA_W'($urandom_range(0, 255));
    end
    #1;
    ctrl_nst = ctrl_st;
    if (rst_b) begin
      case (ctrl_st)
        0: if (start) begin
          load_regs = 1'b1;
          ctrl_nst  = 1;
          load_cyc  = cyc;
          if (ld_q.size() == 0) check("start_without_operand", 1, 0);
          else shadow = ld_q.pop_front();
        end
        1: begin
          incr_r2 = 1'b1;
          check("zero", int'(zero), int'(shadow == '0));
          ctrl_nst = zero ? 0 : 2;
        end
        2: begin
          shift    = 1'b1;
          shadow_e = shadow[DATA_W-1];
          shadow   = shadow << 1;
          ctrl_nst = 3;
        end
        default: begin
          check("E", int'(e_out), int'(shadow_e));
          ctrl_nst = e_out ? 1 : 2;
        end
      endcase
    end
    #1;
    if (in_valid && in_ready && rst_b) begin
      exp_q.push_back(feed_e_q.pop_front());
      ld_q.push_back(feed_d_q.pop_front());
      hold_offer = 1'b0;
    end else begin
      hold_offer = in_valid;
    end
    if (rst_b && out_valid && !prev_ov) begin
      ov_rises++;
      last_lat = cyc - load_cyc;
    end
    prev_ov = out_valid;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_result", int'(out_count), -1);
      else check("out_count", int'(out_count), int'(exp_q.pop_front()));
    end
  endtask

  task automatic run_until_empty(input int budget, input bit rand_mode);
    int left;
    for (int i = 0; i < budget; i++) begin
      if (feed_d_q.size() == 0 && exp_q.size() == 0 && !hold_offer) break;
      if (rand_mode) tick(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      else tick(1'b1, 1'b1);
    end
    left = feed_d_q.size() + exp_q.size();
    check("drain_within_budget", left, 0);
    repeat (3) tick(1'b0, 1'b1);
  endtask

  task automatic clear_model();
    exp_q.delete();
    feed_d_q.delete();
    feed_e_q.delete();
    ld_q.delete();
    hold_offer = 1'b0;
  endtask

  initial begin
    rst_b = 1'b0; in_data = '0; in_valid = 1'b0; rdy = 1'b0;
    load_regs = 1'b0; incr_r2 = 1'b0; shift = 1'b0; out_ready = 1'b1;

    tbl[0] = '{8'hB2, 4'd4};
    tbl[1] = '{8'h00, 4'd0};
    tbl[2] = '{8'hFF, 4'd8};
    tbl[3] = '{8'h01, 4'd1};
    tbl[4] = '{8'h80, 4'd1};
    tbl[5] = '{8'h55, 4'd4};
    tbl[6] = '{8'h7E, 4'd6};
    tbl[7] = '{8'h0F, 4'd4};

    // reset values
    rst_next = 1'b0;
    repeat (3) tick(1'b0, 1'b1);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_count", int'(out_count), 0);
    check("rst_zero", int'(zero), 1);
    check("rst_E", int'(e_out), 0);
    check("rst_start", int'(start), 0);
    rst_next = 1'b1;
    tick(1'b0, 1'b1);

    // directed table, one operand at a time
    for (int i = 0; i < 8; i++) begin
      ov_rises = 0;
      push_op(tbl[i].d, tbl[i].c);
      run_until_empty(200, 1'b0);
      check($sformatf("pulses_%02h", tbl[i].d), ov_rises, 1);
      if (tbl[i].d == 8'h00) check("latency_00", last_lat, 2);
    end

    // back-to-back with the consumer stalled
    push_op(8'h01, 4'd1);
    push_op(8'h80, 4'd1);
    for (int i = 0; i < 100; i++) begin
      if (out_valid) break;
      tick(1'b1, 1'b0);
    end
    repeat (10) tick(1'b1, 1'b0);
    check("stall_out_valid", int'(out_valid), 1);
    check("stall_out_count", int'(out_count), 1);
    check("stall_start", int'(start), 0);
    check("stall_in_ready", int'(in_ready), 0);
    run_until_empty(200, 1'b0);

    // reset in the middle of an operation
    push_op(8'hF0, 4'd4);
    for (int i = 0; i < 50; i++) begin
      tick(1'b1, 1'b1);
      if (ctrl_st == 2) break;
    end
    check("reached_S2", ctrl_st, 2);
    rst_next = 1'b0;
    clear_model();
    push_op(8'h03, 4'd2);
    repeat (3) begin
      tick(1'b1, 1'b1);
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_in_ready", int'(in_ready), 1);
      check("midrst_zero", int'(zero), 1);
    end
    rst_next = 1'b1;
    ov_rises = 0;
    run_until_empty(200, 1'b0);
    check("post_rst_pulses", ov_rises, 1);

    // random operands with random upstream/downstream pacing
    for (int i = 0; i < 200; i++) begin
      logic [DATA_W-1:0] d;
      d = DATA_W'($urandom_range(0, 255));
      push_op(d, ref_ones(d));
    end
    run_until_empty(30000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
